// File: rtl/midi_pkg.sv
// MIDI status-class constants, FSM state types and message-length decode shared by the TX and RX paths.
// Pure definitions: no latency and no backpressure of its own.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF   = 8'h80;
    localparam logic [7:0] NOTE_ON    = 8'h90;
    localparam logic [7:0] POLY_AT    = 8'hA0;
    localparam logic [7:0] CTRL_CHG   = 8'hB0;
    localparam logic [7:0] PROG_CHG   = 8'hC0;
    localparam logic [7:0] CHAN_AT    = 8'hD0;
    localparam logic [7:0] PITCH_BEND = 8'hE0;
    localparam logic [7:0] SYSEX      = 8'hF0;
    localparam logic [7:0] MTC_QF     = 8'hF1;
    localparam logic [7:0] SONG_POS   = 8'hF2;
    localparam logic [7:0] SONG_SEL   = 8'hF3;
    localparam logic [7:0] SYSRT_BASE = 8'hF8;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_BAD
    } seq_state_e;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;

    // Number of data bytes following a status byte; 0 for non-status input.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [3:0] cls;
        logic [1:0] len;
        cls = status[7:4];
        len = 2'd0;
        if (!status[7]) begin
            len = 2'd0;
        end else if (cls == NOTE_OFF[7:4] || cls == NOTE_ON[7:4] || cls == POLY_AT[7:4] ||
                     cls == CTRL_CHG[7:4] || cls == PITCH_BEND[7:4]) begin
            len = 2'd2;
        end else if (cls == PROG_CHG[7:4] || cls == CHAN_AT[7:4]) begin
            len = 2'd1;
        end else if (status == SONG_POS) begin
            len = 2'd2;
        end else if (status == MTC_QF || status == SONG_SEL) begin
            len = 2'd1;
        end
        return len;
    endfunction

    function automatic logic midi_is_channel(input logic [7:0] status);
        return (status >= NOTE_OFF) && (status < SYSEX);
    endfunction

    function automatic logic midi_is_realtime(input logic [7:0] status);
        return status >= SYSRT_BASE;
    endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// One 8N1 UART frame, LSB first: line drops the cycle after start_i and the frame lasts 10*CLKS_PER_BIT clocks.
// done_o is high in the last clock of the stop bit so a new start_i there chains frames with no gap.
module midi_uart_tx_byte
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       line_o,
    output logic       done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    bit_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          line_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign done_o  = (state_q == BIT_STOP) && bit_end;
    assign line_o  = line_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            line_q  <= 1'b1;
        end else if (start_i) begin
            // Start wins over everything, including the final stop-bit clock.
            state_q <= BIT_START;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= byte_i;
            line_q  <= 1'b0;
        end else begin
            if (state_q != BIT_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
            end
            case (state_q)
                BIT_IDLE: begin
                    line_q <= 1'b1;
                end
                BIT_START: begin
                    if (bit_end) begin
                        state_q <= BIT_DATA;
                        idx_q   <= 3'd0;
                        line_q  <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
                BIT_DATA: begin
                    if (bit_end) begin
                        if (idx_q == 3'd7) begin
                            state_q <= BIT_STOP;
                            line_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            line_q  <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                BIT_STOP: begin
                    if (bit_end) begin
                        state_q <= BIT_IDLE;
                    end
                end
                default: begin
                    state_q <= BIT_IDLE;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT message sequencer: start bit on tx the cycle after accept, (1+N)*10 bit-times per message.
// msg_ready only while idle and reopens on the final stop edge; MIDI_RUNNING_STATUS_EN omits repeated channel status.
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD_RATE = 31250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       tx,
    output logic       busy,
    output logic       bad_status
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;

    seq_state_e state_q;
    logic [7:0] status_q;
    logic [6:0] data1_q;
    logic [6:0] data2_q;
    logic [1:0] pos_q;
    logic [1:0] last_q;
    logic       ready_q;
    logic       busy_q;
    logic       bad_q;

    logic       accept;
    logic       skip_status;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic [1:0] next_pos_d;

    assign accept     = msg_valid && ready_q;
    assign msg_ready  = ready_q;
    assign busy       = busy_q;
    assign bad_status = bad_q;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] run_status_q;

    assign skip_status = midi_is_channel(msg_status) && (msg_status == run_status_q);

    // Zero never matches a legal status, so it doubles as "no running status".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_status_q <= 8'h00;
        end else if (accept && msg_status[7]) begin
            if (midi_is_channel(msg_status)) begin
                run_status_q <= msg_status;
            end else if (!midi_is_realtime(msg_status)) begin
                run_status_q <= 8'h00;
            end
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    // The first byte goes straight from the inputs so the start bit leaves one cycle after accept.
    always_comb begin
        tx_start   = 1'b0;
        tx_byte    = status_q;
        next_pos_d = pos_q + 2'd1;
        if (accept && msg_status[7]) begin
            tx_start = 1'b1;
            tx_byte  = skip_status ? {1'b0, msg_data1[6:0]} : msg_status;
        end else if (state_q == SEQ_SEND && tx_done && pos_q != last_q) begin
            tx_start = 1'b1;
            case (next_pos_d)
                2'd1:    tx_byte = {1'b0, data1_q};
                2'd2:    tx_byte = {1'b0, data2_q};
                default: tx_byte = status_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            status_q <= 8'h00;
            data1_q  <= 7'h00;
            data2_q  <= 7'h00;
            pos_q    <= 2'd0;
            last_q   <= 2'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (msg_valid) begin
                        ready_q  <= 1'b0;
                        status_q <= msg_status;
                        data1_q  <= msg_data1[6:0];
                        data2_q  <= msg_data2[6:0];
                        if (!msg_status[7]) begin
                            state_q <= SEQ_BAD;
                            bad_q   <= 1'b1;
                        end else begin
                            state_q <= SEQ_SEND;
                            busy_q  <= 1'b1;
                            pos_q   <= skip_status ? 2'd1 : 2'd0;
                            last_q  <= midi_data_len(msg_status);
                        end
                    end
                end
                SEQ_SEND: begin
                    if (tx_done) begin
                        if (pos_q == last_q) begin
                            state_q <= SEQ_IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            pos_q <= next_pos_d;
                        end
                    end
                end
                SEQ_BAD: begin
                    // Return to idle with ready still low; idle reopens it a cycle later.
                    state_q <= SEQ_IDLE;
                end
                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
        end
    end

    midi_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(tx_start),
        .byte_i (tx_byte),
        .line_o (tx),
        .done_o (tx_done)
    );

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx at 16 clocks per bit: decodes tx frames and times ready/busy edges.
module tb_midi_tx;

    localparam int BIT_CLKS   = 16;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic       clk;
    logic       rst_n;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic       msg_valid;
    logic       msg_ready;
    logic       tx;
    logic       busy;
    logic       bad_status;

    int vectors;
    int miscompares;
    int cyc;

    midi_tx #(
        .CLK_RATE (500000),
        .BAUD_RATE(31250)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_status(msg_status),
        .msg_data1 (msg_data1),
        .msg_data2 (msg_data2),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .tx        (tx),
        .busy      (busy),
        .bad_status(bad_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one message; returns at the negedge after the accepting edge.
    task automatic send_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                            output int t0);
        int n;
        n = 0;
        while (msg_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", {31'd0, msg_ready}, 32'd1);
        msg_status = st;
        msg_data1  = d1;
        msg_data2  = d2;
        msg_valid  = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        t0 = cyc;
        check("ready_drop", {31'd0, msg_ready}, 32'd0);
    endtask

    // Decode one 8N1 frame, sampling mid-bit; ok clears on timeout or framing error.
    task automatic recv_byte(output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b1;
        b  = 8'h00;
        n  = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (BIT_CLKS / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            b[i] = tx;
        end
        repeat (BIT_CLKS) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic wait_ready(input int t0, input int nclk, input string tag);
        int n;
        n = 0;
        while (msg_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_time"}, cyc - t0, nclk);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                           input int nb, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input string tag);
        logic [7:0] exp_b[3];
        logic [7:0] got;
        logic       ok;
        int         t0;
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        send_msg(st, d1, d2, t0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < nb; i++) begin
            recv_byte(got, ok);
            check($sformatf("%s_byte%0d", tag, i), {23'd0, ok, got}, {23'd0, 1'b1, exp_b[i]});
        end
        wait_ready(t0, nb * FRAME_CLKS, tag);
    endtask

    initial begin
        int         t0;
        int         n;
        logic [7:0] got;
        logic       ok;

        vectors     = 0;
        miscompares = 0;
        rst_n      = 1'b0;
        msg_status = 8'h00;
        msg_data1  = 8'h00;
        msg_data2  = 8'h00;
        msg_valid  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, msg_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bad", {31'd0, bad_status}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", {31'd0, msg_ready}, 32'd1);

        // Note on: three frames, first start bit right after accept
        send_msg(8'h90, 8'h3C, 8'h64, t0);
        check("t1_tx_start", {31'd0, tx}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        recv_byte(got, ok);
        check("t1_byte0", {23'd0, ok, got}, {23'd0, 1'b1, 8'h90});
        recv_byte(got, ok);
        check("t1_byte1", {23'd0, ok, got}, {23'd0, 1'b1, 8'h3C});
        recv_byte(got, ok);
        check("t1_byte2", {23'd0, ok, got}, {23'd0, 1'b1, 8'h64});
        wait_ready(t0, 480, "t1");

        // Program change: data2 never sent
        run_msg(8'hC5, 8'h07, 8'h55, 2, 8'hC5, 8'h07, 8'h00, "t2");
        check("t2_tx_idle", {31'd0, tx}, 32'd1);

        // Real-time F8 with msg_valid held during busy
        send_msg(8'hF8, 8'h00, 8'h00, t0);
        msg_status = 8'hC0;
        msg_valid  = 1'b1;
        recv_byte(got, ok);
        check("t3_byte0", {23'd0, ok, got}, {23'd0, 1'b1, 8'hF8});
        msg_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t3_busy_len", cyc - t0, 160);
        check("t3_ready", {31'd0, msg_ready}, 32'd1);

        // Bad status
        send_msg(8'h3C, 8'h40, 8'h00, t0);
        check("t4_bad_pulse", {31'd0, bad_status}, 32'd1);
        check("t4_tx_high", {31'd0, tx}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t4_bad_end", {31'd0, bad_status}, 32'd0);
        check("t4_ready_low", {31'd0, msg_ready}, 32'd0);
        @(negedge clk);
        check("t4_ready_back", {31'd0, msg_ready}, 32'd1);
        check("t4_tx_still_high", {31'd0, tx}, 32'd1);

        // Data bit7 masked, then reset during data bit 3 of the third byte (0x40)
        send_msg(8'h90, 8'hBC, 8'h40, t0);
        recv_byte(got, ok);
        check("t5_byte0", {23'd0, ok, got}, {23'd0, 1'b1, 8'h90});
        recv_byte(got, ok);
        check("t5_byte1_masked", {23'd0, ok, got}, {23'd0, 1'b1, 8'h3C});
        n = 0;
        while (cyc < t0 + 390 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_tx_bit3", {31'd0, tx}, 32'd0);
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_ready", {31'd0, msg_ready}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after", {31'd0, msg_ready}, 32'd1);
        check("t5_tx_after", {31'd0, tx}, 32'd1);

        // Running-status sequence
`ifdef MIDI_RUNNING_STATUS_EN
        run_msg(8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, "t6a");
        run_msg(8'h90, 8'h3E, 8'h64, 2, 8'h3E, 8'h64, 8'h00, "t6b");
        run_msg(8'hF8, 8'h00, 8'h00, 1, 8'hF8, 8'h00, 8'h00, "t6c");
        run_msg(8'h90, 8'h40, 8'h64, 2, 8'h40, 8'h64, 8'h00, "t6d");
        run_msg(8'hF2, 8'h00, 8'h00, 3, 8'hF2, 8'h00, 8'h00, "t6e");
        run_msg(8'h90, 8'h3C, 8'h00, 3, 8'h90, 8'h3C, 8'h00, "t6f");
`else
        run_msg(8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, "t6a");
        run_msg(8'h90, 8'h3E, 8'h64, 3, 8'h90, 8'h3E, 8'h64, "t6b");
        run_msg(8'hF8, 8'h00, 8'h00, 1, 8'hF8, 8'h00, 8'h00, "t6c");
        run_msg(8'h90, 8'h40, 8'h64, 3, 8'h90, 8'h40, 8'h64, "t6d");
        run_msg(8'hF2, 8'h00, 8'h00, 3, 8'hF2, 8'h00, 8'h00, "t6e");
        run_msg(8'h90, 8'h3C, 8'h00, 3, 8'h90, 8'h3C, 8'h00, "t6f");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
